// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer_pkg
// Brief    : State encoding, parameter defaults and counter sizing for the
//            per-domain reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_HOLD  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_VIDEO = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   localparam int C_HOLD_CYCLES_DEF    = 16;
   localparam int C_INIT_TIMEOUT_DEF   = 1024;
   localparam int C_STAGGER_CYCLES_DEF = 4;

   // Width that can hold the largest terminal count of the three phases.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Brief    : Releases core, video and bus resets in order, with a memory-init
//            window between core and video release; soft reset re-runs it.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int HOLD_CYCLES    = C_HOLD_CYCLES_DEF,
   parameter int INIT_TIMEOUT   = C_INIT_TIMEOUT_DEF,
   parameter int STAGGER_CYCLES = C_STAGGER_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic soft_reset_req,
   input  logic init_done,
   output logic core_rst,
   output logic video_rst,
   output logic bus_rst,
   output logic init_start,
   output logic ready,
   output logic init_timeout
);

   localparam int CW = cnt_width(HOLD_CYCLES, INIT_TIMEOUT, STAGGER_CYCLES);

   localparam logic [CW-1:0] C_HOLD_LAST    = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] C_INIT_LAST    = CW'(INIT_TIMEOUT - 1);
   localparam logic [CW-1:0] C_STAGGER_LAST = CW'(STAGGER_CYCLES - 1);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_core_rst;
   logic            r_video_rst;
   logic            r_bus_rst;
   logic            r_init_start;
   logic            r_ready;
   logic            r_init_timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_HOLD;
         r_cnt          <= '0;
         r_core_rst     <= 1'b1;
         r_video_rst    <= 1'b1;
         r_bus_rst      <= 1'b1;
         r_init_start   <= 1'b0;
         r_ready        <= 1'b0;
         r_init_timeout <= 1'b0;
      end else begin
         r_init_start <= 1'b0;
         if (soft_reset_req) begin
            r_state     <= ST_HOLD;
            r_cnt       <= '0;
            r_core_rst  <= 1'b1;
            r_video_rst <= 1'b1;
            r_bus_rst   <= 1'b1;
            r_ready     <= 1'b0;
         end else begin
            case (r_state)
               ST_HOLD: begin
                  if (r_cnt == C_HOLD_LAST) begin
                     r_state      <= ST_CLEAR;
                     r_core_rst   <= 1'b0;
                     r_init_start <= 1'b1;
                     r_cnt        <= '0;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               ST_CLEAR: begin
                  // r_init_start marks the first CLEAR cycle, where a
                  // leftover init_done level must not count as completion.
                  if (init_done && !r_init_start) begin
                     r_state     <= ST_VIDEO;
                     r_video_rst <= 1'b0;
                     r_cnt       <= '0;
                  end else if (r_cnt == C_INIT_LAST) begin
                     r_state        <= ST_VIDEO;
                     r_video_rst    <= 1'b0;
                     r_init_timeout <= 1'b1;
                     r_cnt          <= '0;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               ST_VIDEO: begin
                  if (r_cnt == C_STAGGER_LAST) begin
                     r_state   <= ST_RUN;
                     r_bus_rst <= 1'b0;
                     r_ready   <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               default: begin
                  r_state <= ST_RUN;
               end
            endcase
         end
      end
   end

   assign core_rst     = r_core_rst;
   assign video_rst    = r_video_rst;
   assign bus_rst      = r_bus_rst;
   assign init_start   = r_init_start;
   assign ready        = r_ready;
   assign init_timeout = r_init_timeout;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Randomized scoreboard bench; expectations come from an
//            event-time model of the release schedule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

   localparam int HOLD = 4;
   localparam int TO   = 8;
   localparam int STG  = 2;

   typedef struct packed {
      logic core;
      logic video;
      logic bus;
      logic start;
      logic rdy;
      logic tmo;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic soft_reset_req = 1'b0;
   logic init_done = 1'b0;
   logic core_rst, video_rst, bus_rst, init_start, ready, init_timeout;

   int n_test = 0;
   int n_fail = 0;
   exp_t q[$];

   // Model: edge count since rst release, anchor edge of the latest hold,
   // edge at which video was released (-1 = not yet) and sticky timeout.
   int m_n, m_anchor, m_v;
   bit m_to;

   always #5 clk = ~clk;

   reset_sequencer #(
      .HOLD_CYCLES   (HOLD),
      .INIT_TIMEOUT  (TO),
      .STAGGER_CYCLES(STG)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .soft_reset_req(soft_reset_req),
      .init_done     (init_done),
      .core_rst      (core_rst),
      .video_rst     (video_rst),
      .bus_rst       (bus_rst),
      .init_start    (init_start),
      .ready         (ready),
      .init_timeout  (init_timeout)
   );

   function automatic exp_t dut_out();
      return '{core_rst, video_rst, bus_rst, init_start, ready, init_timeout};
   endfunction

   task automatic model_reset();
      m_n = 0; m_anchor = 0; m_v = -1; m_to = 1'b0;
   endtask

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
      n_test++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %b required %b (core,video,bus,start,ready,tmo)", name, act, req);
      end
   endtask

   // Drives one clock's inputs and predicts the outputs after the next edge.
   task automatic drive(input logic sr, input logic dn);
      exp_t e;
      int   c;
      soft_reset_req = sr;
      init_done      = dn;
      m_n++;
      if (sr) begin
         m_anchor = m_n;
         m_v      = -1;
      end else if (m_v < 0) begin
         c = m_anchor + HOLD;
         if (dn && m_n >= c + 2) m_v = m_n;
         else if (m_n == c + TO) begin
            m_v  = m_n;
            m_to = 1'b1;
         end
      end
      c       = m_anchor + HOLD;
      e.core  = (m_n < c);
      e.start = (m_n == c);
      e.video = (m_v < 0);
      e.bus   = (m_v < 0) || (m_n < m_v + STG);
      e.rdy   = !e.bus;
      e.tmo   = m_to;
      q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: pops one expectation per edge and checks ordering throughout.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("edge%0d", m_n), dut_out(), e);
         end
         if (!rst) begin
            n_test++;
            if ((core_rst && !video_rst) || (video_rst && !bus_rst)) begin
               n_fail++;
               $display("FAIL order: core=%b video=%b bus=%b required core<=video<=bus",
                        core_rst, video_rst, bus_rst);
            end
         end
      end
   end

   initial begin
      int k;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_state", dut_out(), 6'b111000);
      rst = 1'b0;

      // Nominal release with done pulse at edge 7
      for (int i = 1; i <= 12; i++) drive(1'b0, i == 7);
      // Soft reset from RUN, same timing relative to request edge
      drive(1'b1, 1'b0);
      for (int i = 1; i <= 12; i++) drive(1'b0, i == 7);
      // Timeout
      drive(1'b1, 1'b0);
      for (int i = 1; i <= 16; i++) drive(1'b0, 1'b0);
      // Stale done held high; timeout flag must survive soft reset
      drive(1'b1, 1'b0);
      for (int i = 1; i <= 10; i++) drive(1'b0, 1'b1);
      // Done on the terminal-count cycle
      drive(1'b1, 1'b0);
      for (int i = 1; i <= 16; i++) drive(1'b0, i == HOLD + TO);
      // Extended hold
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
      for (int i = 1; i <= 12; i++) drive(1'b0, i == 6);

      // Randomized traffic, with done held in bursts from time to time
      k = 0;
      for (int i = 0; i < 800; i++) begin
         if (k == 0 && $urandom_range(0, 19) == 0) k = $urandom_range(1, 6);
         drive($urandom_range(0, 99) < 3, (k > 0) || ($urandom_range(0, 9) == 0));
         if (k > 0) k--;
      end

      // Async reset mid-CLEAR with the timeout flag set
      drive(1'b1, 1'b0);
      for (int i = 1; i <= HOLD + TO + 2; i++) drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      for (int i = 1; i <= HOLD + 2; i++) drive(1'b0, 1'b0);
      check("pre_async_clear", dut_out(), 6'b011001);
      soft_reset_req = 1'b0;
      init_done      = 1'b0;
      #2 rst = 1'b1;
      #1 check("async_reset", dut_out(), 6'b111000);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 1; i <= 12; i++) drive(1'b0, i == 7);

      @(posedge clk);
      #2;
      n_test++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the reset synchronizer. It takes the synchronized reset and sequences the per-domain resets: core logic first, then the video pipeline, then the host bus interface.
- Gives the memory-init engine (VRAM/palette clear) a window to run between core release and video release.
- Handles software reset requests from the host register interface by re-running the full sequence.

Parameters:
- HOLD_CYCLES, 16: clocks all resets stay asserted after rst deasserts or after the last soft reset request; must be ≥1.
- INIT_TIMEOUT, 1024: maximum clocks spent waiting for init_done before forcing progress; must be ≥2.
- STAGGER_CYCLES, 4: clocks between video_rst release and bus_rst release; must be ≥1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset; asynchronous, active-high; driven by the synchronizer output.
- soft_reset_req, input, 1: single-clock request from the host register write; a held level is treated as repeated requests.
- init_done, input, 1: memory-init engine reports completion.
- core_rst, output, 1: reset to core/register logic, active-high.
- video_rst, output, 1: reset to the video composer and pipeline, active-high.
- bus_rst, output, 1: reset to the host bus interface, active-high.
- init_start, output, 1: one-clock pulse that starts the memory-init engine.
- ready, output, 1: high once the full sequence is complete.
- init_timeout, output, 1: sticky flag; set when INIT_TIMEOUT expired without init_done.

Behaviour:
- All outputs are registered. Counter width = $clog2(max(HOLD_CYCLES, INIT_TIMEOUT, STAGGER_CYCLES)+1).
- rst high, asynchronously and immediately, with no clock edge needed:
  - state=HOLD, counter=0
  - core_rst=1, video_rst=1, bus_rst=1
  - init_start=0, ready=0, init_timeout=0
- HOLD:
  - All three resets =1; counter increments every clk.
  - On the edge where counter==HOLD_CYCLES-1: state→CLEAR, core_rst←0, init_start←1, counter←0.
  - With edge 1 = first edge after rst falls, core_rst falls at edge HOLD_CYCLES.
- CLEAR:
  - init_start is high only on the first CLEAR cycle; init_done is ignored on that cycle so a stale level is not taken as completion.
  - From the second CLEAR cycle on, init_done=1 → state←VIDEO, video_rst←0, counter←0.
  - Otherwise, when counter==INIT_TIMEOUT-1: same transition, and init_timeout←1.
  - If init_done and terminal count occur in the same cycle, init_done wins and init_timeout is not set.
- VIDEO:
  - video_rst=0; counter increments.
  - On the edge where counter==STAGGER_CYCLES-1: state←RUN, bus_rst←0, ready←1.
- RUN: all resets 0, ready=1; state is held indefinitely.
- soft_reset_req=1 in CLEAR, VIDEO or RUN:
  - Next edge: state←HOLD, counter←0, all resets←1, ready←0, init_start←0.
  - init_timeout is kept; only rst clears it.
- soft_reset_req=1 in HOLD: counter←0, which extends the hold; core_rst falls HOLD_CYCLES edges after the last request.
- init_done outside CLEAR: ignored.
- soft_reset_req takes priority over every other transition in the same cycle.
- Reset ordering invariant: core_rst ≤ video_rst ≤ bus_rst (deasserted-first ordering) holds in every cycle.

Decomposition:
- Shared package/include holds:
  - the state encoding (HOLD=2'd0, CLEAR=2'd1, VIDEO=2'd2, RUN=2'd3);
  - the parameter defaults;
  - a localparam function for the counter width.
- Single module; no sub-module needed. The counter stays inline with the FSM.

Test Plan (HOLD_CYCLES=4, INIT_TIMEOUT=8, STAGGER_CYCLES=2; edge numbering starts at 1 after rst falls):
- Nominal release: rst falls; init_done pulse at edge 7 → core_rst 0 at edge 4; init_start high only for the cycle after edge 4; video_rst 0 at edge 7; bus_rst 0 and ready 1 at edge 9; init_timeout 0.
- Timeout: init_done held 0 → video_rst 0 and init_timeout 1 at edge 12; bus_rst 0 at edge 14; init_timeout stays 1 through a later soft reset.
- Stale done and same-cycle tie:
  - init_done held 1 from rst release → ignored at edge 5 (first CLEAR cycle); video_rst falls at edge 6.
  - Separate run: init_done asserted exactly on the terminal-count cycle → transition occurs and init_timeout stays 0.
- Soft reset from RUN: one-cycle soft_reset_req → next edge all resets 1 and ready 0; sequence repeats with the same 4/…/2 timing relative to that edge.
- Extended hold: soft_reset_req held for 3 cycles starting in HOLD → core_rst falls 4 edges after the last request cycle; init_start pulses exactly once.
- Async reset mid-CLEAR: rst raised between clock edges → core_rst, video_rst and bus_rst read 1, and ready and init_timeout read 0, before the next clk edge; ordering invariant checked by assertion throughout.
